interp_block_sequencer: RTL and testbench
=========================================

Name: interp_block_sequencer

Overview:
- Control FSM for the 8x8 subpixel interpolation datapath. It accepts one 15x15 reference block row by row, runs the horizontal FIR pass and then the vertical FIR pass, and presents a completed block on a valid/ready handshake.
- Replaces the free-running counter and modulo-decoded load strobes with explicit phase control and backpressure.
- Drives the input shift register, input mux select, half-pel shift registers and output fillers.

Parameters:
- NUM_PIXEL, 8, output pixels per row/column.
- TAPS, 8, FIR taps; ROWS = NUM_PIXEL+TAPS-1 = 15.
- FIR_LAT, 2, FIR register latency in cycles; range 1..4.
- CNT_W, 8, phase counter width; must hold ROWS.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  begin a block; sampled in IDLE or on HOLD handshake.
- flush  in  1  synchronous abort to IDLE.
- row_valid  in  1  in_row word is valid.
- row_ready  out  1  sequencer accepts a row.
- load_in  out  1  input shift-register enable; = row_valid & row_ready.
- sel  out  8  input mux select; phase counter, zero-extended.
- hv_mode  out  1  0 = horizontal pass feeds the FIRs, 1 = vertical pass.
- h_shift_en  out  1  half-pel shift registers capture FIR outputs.
- out_capt_en  out  1  output fillers capture FIR outputs.
- out_idx  out  8  output filler row index; sel delayed FIR_LAT.
- out_valid  out  1  out_A/B/C block is complete.
- out_ready  in  1  consumer takes the block.
- busy  out  1  state != IDLE.
- blk_done  out  1  one-cycle pulse on the out_valid & out_ready cycle.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, counter 0, latency pipe cleared. All outputs 0.
- IDLE: row_ready=0. If start, go to LOAD with cnt=0.
- LOAD: row_ready=1. Each accepted row increments cnt. When row ROWS-1 is accepted, go to HPASS with cnt=0. row_valid low stalls the FSM indefinitely with no timeout.
- HPASS: sel=cnt, hv_mode=0, cnt runs 0..ROWS-1, one row per cycle, no stall. After cnt=ROWS-1, go to VPASS with cnt=0.
- VPASS: sel=cnt, hv_mode=1, cnt runs 0..NUM_PIXEL-1. Then go to DRAIN.
- DRAIN: lasts exactly FIR_LAT cycles. Then go to HOLD.
- HOLD: out_valid=1 and held until out_ready.
  - On handshake: blk_done=1 for that cycle.
  - Next state is LOAD if start is high that cycle, else IDLE.
  - out_valid drops the cycle after the handshake.
- Latency pipe (FIR_LAT deep) carries {valid, tag, idx}. It is loaded with {1,0,cnt} in HPASS, {1,1,cnt} in VPASS, and zeros otherwise.
  - Pipe outputs: h_shift_en = v & !tag; out_capt_en = v & tag; out_idx = idx.
  - The pipe keeps shifting in every state, so the last VPASS capture lands in the final DRAIN cycle.
- Timing with FIR_LAT=2 and row_valid held high:
  - start sampled at edge 0.
  - LOAD cycles 1..15, HPASS 16..30, VPASS 31..38, DRAIN 39..40.
  - out_valid first high in cycle 41; start-to-out_valid = 1+ROWS+ROWS+NUM_PIXEL+FIR_LAT.
  - out_capt_en high in cycles 33..40 with out_idx 0..7; h_shift_en high in cycles 18..32.
- start is ignored in LOAD, HPASS, VPASS and DRAIN.
- row_valid outside LOAD is ignored; row_ready is 0 and load_in is 0.
- out_ready while out_valid=0 is ignored.
- flush has priority over all transitions. Next cycle: IDLE, cnt=0, pipe cleared, out_valid=0, no blk_done.
  - flush and out handshake in the same cycle: flush wins and blk_done is suppressed.
- Reset mid-block: immediate asynchronous return to IDLE with all outputs 0. The partial block is discarded and the datapath contents are don't-care.
- Counter never wraps. Every exit compare is equality against ROWS-1 or NUM_PIXEL-1.

Decomposition:
- Shared header interp_defs.vh holds:
  - state encodings: IDLE, LOAD, HPASS, VPASS, DRAIN, HOLD, 3-bit;
  - NUM_PIXEL, TAPS, ROWS, FIR_LAT defaults.
- The top-level datapath uses the same header.
- One sub-module, lat_pipe: a parameterised FIR_LAT-deep, width-W delay line with synchronous clear and asynchronous active-low reset. It is instanced once for {valid, tag, idx[7:0]}.

Test Plan:
- Nominal: reset, start pulse, row_valid held high, out_ready high. Required: load_in high exactly 15 cycles (1..15); h_shift_en cycles 18..32; out_capt_en cycles 33..40 with out_idx 0..7; out_valid at cycle 41; blk_done one pulse; return to IDLE.
- Row backpressure: toggle row_valid every cycle. Required: exactly 15 load_in pulses; HPASS starts the cycle after the 15th accept; out_valid 14 cycles later than nominal.
- Output backpressure: out_ready low for 10 cycles in HOLD. Required: out_valid stays high, no blk_done, state held; release gives a single blk_done.
- Back-to-back: start held high. Required: HOLD handshake goes directly to LOAD with row_ready=1 the next cycle; the second block's out_valid comes 41 cycles after the first handshake cycle.
- Flush in VPASS at sel=3. Required: next cycle busy=0, no further out_capt_en, no blk_done; stray start during HPASS has no effect.
- Async reset in LOAD after 7 rows. Required: all outputs 0 immediately; after release a new start requires a full 15 rows.

Source files
------------

// File: rtl/interp_block_sequencer_pkg.sv
// Shared constants, state encoding and latency-pipe word for the 8x8 subpixel
// interpolation sequencer.
package interp_block_sequencer_pkg;

  localparam int DEF_NUM_PIXEL = 8;
  localparam int DEF_TAPS      = 8;
  localparam int DEF_ROWS      = DEF_NUM_PIXEL + DEF_TAPS - 1;
  localparam int DEF_FIR_LAT   = 2;
  localparam int DEF_CNT_W     = 8;
  localparam int SEL_W         = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    HPASS = 3'd2,
    VPASS = 3'd3,
    DRAIN = 3'd4,
    HOLD  = 3'd5
  } seq_state_e;

  typedef struct packed {
    logic             v;
    logic             tag;
    logic [SEL_W-1:0] idx;
  } lat_word_t;

endpackage

// File: rtl/interp_block_sequencer_if.sv
// Control/handshake bundle between the interpolation sequencer and its datapath.
interface interp_block_sequencer_if;
  import interp_block_sequencer_pkg::*;

  logic             start;
  logic             flush;
  logic             row_valid;
  logic             row_ready;
  logic             load_in;
  logic [SEL_W-1:0] sel;
  logic             hv_mode;
  logic             h_shift_en;
  logic             out_capt_en;
  logic [SEL_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             blk_done;

  modport master (
    input  start, flush, row_valid, out_ready,
    output row_ready, load_in, sel, hv_mode, h_shift_en, out_capt_en,
           out_idx, out_valid, busy, blk_done
  );

  modport slave (
    output start, flush, row_valid, out_ready,
    input  row_ready, load_in, sel, hv_mode, h_shift_en, out_capt_en,
           out_idx, out_valid, busy, blk_done
  );

endinterface

// File: rtl/interp_block_sequencer_lat_pipe.sv
// DEPTH-stage, W-bit delay line matching the FIR register latency; clr empties
// every stage on the next edge.
module interp_block_sequencer_lat_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/interp_block_sequencer.sv
// Phase controller for the 8x8 subpixel interpolator: load ROWS rows, horizontal
// FIR pass, vertical FIR pass, drain FIR latency, then hold the block for the consumer.
// state | meaning: IDLE wait start | LOAD accept rows | HPASS horizontal FIR
//       | VPASS vertical FIR | DRAIN FIR latency | HOLD block valid until taken
module interp_block_sequencer
  import interp_block_sequencer_pkg::*;
#(
  parameter int NUM_PIXEL = DEF_NUM_PIXEL,
  parameter int TAPS      = DEF_TAPS,
  parameter int FIR_LAT   = DEF_FIR_LAT,
  parameter int CNT_W     = DEF_CNT_W
) (
  input logic                      clk,
  input logic                      rst,
  interp_block_sequencer_if.master bus
);

  localparam int ROWS = NUM_PIXEL + TAPS - 1;
  localparam int LW   = $bits(lat_word_t);
  localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] PIX_LAST   = CNT_W'(NUM_PIXEL - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(FIR_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  seq_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             row_ready_q;
  logic             hv_mode_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             accept;
  logic             handshake;
  lat_word_t        pipe_d;
  lat_word_t        pipe_q;
  logic [LW-1:0]    pipe_q_bits;

  assign accept    = bus.row_valid & row_ready_q;
  assign handshake = out_valid_q & bus.out_ready;

  // Output flags are updated together with the state so they come straight from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      row_ready_q <= 1'b0;
      hv_mode_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (bus.flush) begin
      state       <= IDLE;
      cnt         <= '0;
      row_ready_q <= 1'b0;
      hv_mode_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= LOAD;
            cnt         <= '0;
            row_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            if (cnt == ROW_LAST) begin
              state       <= HPASS;
              cnt         <= '0;
              row_ready_q <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        HPASS: begin
          if (cnt == ROW_LAST) begin
            state     <= VPASS;
            cnt       <= '0;
            hv_mode_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        VPASS: begin
          if (cnt == PIX_LAST) begin
            state     <= DRAIN;
            cnt       <= '0;
            hv_mode_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state       <= HOLD;
            cnt         <= '0;
            out_valid_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HOLD: begin
          if (handshake) begin
            out_valid_q <= 1'b0;
            if (bus.start) begin
              state       <= LOAD;
              row_ready_q <= 1'b1;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          row_ready_q <= 1'b0;
          hv_mode_q   <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    pipe_d = '0;
    if (state == HPASS || state == VPASS) begin
      pipe_d.v   = 1'b1;
      pipe_d.tag = (state == VPASS);
      pipe_d.idx = SEL_W'(cnt);
    end
  end

  interp_block_sequencer_lat_pipe #(
    .DEPTH (FIR_LAT),
    .W     (LW)
  ) u_lat_pipe (
    .clk (clk),
    .rst (rst),
    .clr (bus.flush),
    .d   (pipe_d),
    .q   (pipe_q_bits)
  );

  assign pipe_q = pipe_q_bits;

  assign bus.row_ready   = row_ready_q;
  assign bus.load_in     = accept;
  assign bus.sel         = SEL_W'(cnt);
  assign bus.hv_mode     = hv_mode_q;
  assign bus.h_shift_en  = pipe_q.v & ~pipe_q.tag;
  assign bus.out_capt_en = pipe_q.v & pipe_q.tag;
  assign bus.out_idx     = pipe_q.idx;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  // A flush in the handshake cycle discards the block, so no completion pulse.
  assign bus.blk_done    = handshake & ~bus.flush;

endmodule

// File: tb/tb_interp_block_sequencer.sv
// Scoreboard bench: stimulus queues the expected output events with their cycle,
// a negedge monitor pops and compares every event the sequencer actually produces.
module tb_interp_block_sequencer;

  localparam int K_BR  = 0;
  localparam int K_LD  = 1;
  localparam int K_HS  = 2;
  localparam int K_OC  = 3;
  localparam int K_OVR = 4;
  localparam int K_BD  = 5;
  localparam int K_OVF = 6;
  localparam int K_BF  = 7;

  typedef struct {
    int cyc;
    int kind;
    int idx;
  } evt_t;

  logic clk;
  logic rst;
  int   edge_cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   s;
  int   s2;
  logic busy_q = 1'b0;
  logic ov_q = 1'b0;
  evt_t exp_q[$];

  interp_block_sequencer_if bus();

  interp_block_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic int ab(int base, int k);
    return base + k - 1;
  endfunction

  function automatic void push(int c, int k, int ix);
    evt_t e;
    int   pos;
    e.cyc  = c;
    e.kind = k;
    e.idx  = ix;
    pos = exp_q.size();
    while (pos > 0 && (exp_q[pos-1].cyc > c || (exp_q[pos-1].cyc == c && exp_q[pos-1].kind > k)))
      pos--;
    exp_q.insert(pos, e);
  endfunction

  function automatic void push_loads(int base, int first, int last, int step);
    for (int k = first; k <= last; k += step) push(ab(base, k), K_LD, 0);
  endfunction

  // Everything after the last accepted row L: HPASS, VPASS captures, hold of h extra cycles.
  function automatic void push_block(int base, int l, int h, bit bd, bit idle);
    for (int k = l + 3; k <= l + 17; k++) push(ab(base, k), K_HS, 0);
    for (int j = 0; j < 8; j++) push(ab(base, l + 18 + j), K_OC, j);
    push(ab(base, l + 26), K_OVR, 0);
    if (bd) push(ab(base, l + 26 + h), K_BD, 0);
    push(ab(base, l + 27 + h), K_OVF, 0);
    if (idle) push(ab(base, l + 27 + h), K_BF, 0);
  endfunction

  task automatic check(string name, int act, int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic see(int kind, int idx);
    evt_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_evt: got kind=%0d idx=%0d cyc=%0d, expected no event", kind, idx, edge_cnt);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != edge_cnt || e.kind != kind || e.idx != idx) begin
        n_err++;
        $display("FAIL evt: got kind=%0d idx=%0d cyc=%0d, expected kind=%0d idx=%0d cyc=%0d",
                 kind, idx, edge_cnt, e.kind, e.idx, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.busy && !busy_q)          see(K_BR, 0);
    if (bus.load_in)                  see(K_LD, 0);
    if (bus.h_shift_en)               see(K_HS, 0);
    if (bus.out_capt_en)              see(K_OC, int'(bus.out_idx));
    if (bus.out_valid && !ov_q)       see(K_OVR, 0);
    if (bus.blk_done)                 see(K_BD, 0);
    if (!bus.out_valid && ov_q)       see(K_OVF, 0);
    if (!bus.busy && busy_q)          see(K_BF, 0);
    busy_q = bus.busy;
    ov_q   = bus.out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_block(output int base);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    base = edge_cnt;
  endtask

  task automatic drain(string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_zero(string name);
    check(name, int'({bus.row_ready, bus.load_in, bus.sel, bus.hv_mode, bus.h_shift_en,
                      bus.out_capt_en, bus.out_idx, bus.out_valid, bus.busy, bus.blk_done}), 0);
  endtask

  task automatic run_nominal(string name);
    int base;
    bus.row_valid = 1'b1;
    bus.out_ready = 1'b1;
    begin_block(base);
    push(ab(base, 1), K_BR, 0);
    push_loads(base, 1, 15, 1);
    push_block(base, 15, 0, 1'b1, 1'b1);
    for (int k = 1; k <= 45; k++) tick();
    drain(name);
    check({name, "_idle"}, int'(bus.busy), 0);
  endtask

  initial begin
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.flush     = 1'b0;
    bus.row_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check_zero("reset_state");
    rst = 1'b1;
    repeat (2) tick();

    run_nominal("nominal");

    // Row backpressure: row_valid high only in odd cycles, last accept in cycle 29.
    bus.out_ready = 1'b1;
    begin_block(s);
    push(ab(s, 1), K_BR, 0);
    push_loads(s, 1, 29, 2);
    push_block(s, 29, 0, 1'b1, 1'b1);
    for (int k = 1; k <= 60; k++) begin
      bus.row_valid = k[0];
      tick();
    end
    bus.row_valid = 1'b1;
    drain("row_backpressure");

    // Output backpressure: consumer stalls the first 10 HOLD cycles.
    bus.out_ready = 1'b0;
    begin_block(s);
    push(ab(s, 1), K_BR, 0);
    push_loads(s, 1, 15, 1);
    push_block(s, 15, 10, 1'b1, 1'b1);
    for (int k = 1; k <= 60; k++) begin
      bus.out_ready = (k >= 51);
      if (k == 50) check("hold_out_valid", int'(bus.out_valid), 1);
      tick();
    end
    drain("out_backpressure");

    // Back-to-back: start held through the first handshake.
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    tick();
    s  = edge_cnt;
    s2 = s + 41;
    push(ab(s, 1), K_BR, 0);
    push_loads(s, 1, 15, 1);
    push_block(s, 15, 0, 1'b1, 1'b0);
    push_loads(s2, 1, 15, 1);
    push_block(s2, 15, 0, 1'b1, 1'b1);
    for (int k = 1; k <= 90; k++) begin
      bus.start = (k < 50);
      if (k == 42) check("b2b_row_ready", int'(bus.row_ready), 1);
      tick();
    end
    bus.start = 1'b0;
    drain("back_to_back");

    // Flush in VPASS at sel=3, with a stray start during HPASS.
    begin_block(s);
    push(ab(s, 1), K_BR, 0);
    push_loads(s, 1, 15, 1);
    for (int k = 18; k <= 32; k++) push(ab(s, k), K_HS, 0);
    push(ab(s, 33), K_OC, 0);
    push(ab(s, 34), K_OC, 1);
    push(ab(s, 35), K_BF, 0);
    for (int k = 1; k <= 45; k++) begin
      bus.start = (k == 20);
      bus.flush = (k == 34);
      if (k == 34) begin
        check("flush_sel", int'(bus.sel), 3);
        check("flush_hv_mode", int'(bus.hv_mode), 1);
      end
      if (k == 35) check("flush_busy", int'(bus.busy), 0);
      tick();
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    drain("flush_vpass");

    // Flush coincident with the output handshake suppresses blk_done.
    begin_block(s);
    push(ab(s, 1), K_BR, 0);
    push_loads(s, 1, 15, 1);
    push_block(s, 15, 0, 1'b0, 1'b1);
    for (int k = 1; k <= 45; k++) begin
      bus.flush = (k == 41);
      tick();
    end
    bus.flush = 1'b0;
    drain("flush_handshake");

    // Asynchronous reset after 7 accepted rows, then a full new block.
    begin_block(s);
    push(ab(s, 1), K_BR, 0);
    push_loads(s, 1, 7, 1);
    push(ab(s, 8), K_BF, 0);
    for (int k = 1; k <= 7; k++) tick();
    #1;
    rst = 1'b0;
    #1;
    check_zero("reset_mid_load");
    tick();
    tick();
    rst = 1'b1;
    tick();
    drain("reset_mid");
    run_nominal("after_reset");

    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
